// File: rtl/pmod_input_unit.sv
// pmod_input_unit: synchronizes and debounces push-buttons, detects press and
// long-press, and queues them as commands on a valid/ready interface.
module pmod_input_unit #(
    parameter int N_BTN             = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter int CODE_W            = $clog2(2*N_BTN)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [N_BTN-1:0]  i_btn,
    input  logic              i_cmd_ready,
    output logic              o_cmd_valid,
    output logic [CODE_W-1:0] o_cmd_code,
    output logic [N_BTN-1:0]  o_btn_level,
    output logic              o_overrun
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [N_BTN-1:0]            sync1_q, sync1_d;
    logic [N_BTN-1:0]            sync2_q, sync2_d;
    logic [N_BTN-1:0]            stable_q, stable_d;
    logic [N_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [N_BTN-1:0][LP_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [2*N_BTN-1:0]          pend_q, pend_d;
    logic                        overrun_q, overrun_d;
    logic [N_BTN-1:0]            press_evt, long_evt;
    logic [2*N_BTN-1:0]          evt, xfer;

    always_comb begin
        sync1_d    = i_btn;
        sync2_d    = sync1_q;
        stable_d   = stable_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_evt  = '0;
        long_evt   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i]  = sync2_q[i];
                db_cnt_d[i]  = '0;
                press_evt[i] = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
            // A press released on the edge it would mature is not a long press.
            if (!stable_q[i] || !stable_d[i]) begin
                hold_cnt_d[i] = '0;
            end else if (hold_cnt_q[i] != LP_MAX) begin
                hold_cnt_d[i] = hold_cnt_q[i] + LP_W'(1);
                long_evt[i]   = (hold_cnt_q[i] == LP_LAST);
            end
        end
    end

    always_comb begin
        o_cmd_code = '0;
        for (int k = 2*N_BTN-1; k >= 0; k--) begin
            if (pend_q[k]) o_cmd_code = CODE_W'(k);
        end
    end

    assign o_cmd_valid = |pend_q;
    assign o_btn_level = stable_q;
    assign o_overrun   = overrun_q;

    always_comb begin
        evt  = {long_evt, press_evt};
        xfer = '0;
        if (o_cmd_valid && i_cmd_ready) xfer[o_cmd_code] = 1'b1;
        pend_d    = (pend_q & ~xfer) | evt;
        overrun_d = |(evt & pend_q & ~xfer);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            pend_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            pend_q     <= pend_d;
            overrun_q  <= overrun_d;
        end
    end
endmodule

// File: tb/tb_pmod_input_unit.sv
// tb_pmod_input_unit: cycle table for press/bounce timing plus scoreboarded
// sequences for long press, back-pressure, overrun and async reset.
module tb_pmod_input_unit;
    typedef struct {
        logic [2:0] code;
        int         cyc;
    } sb_t;

    typedef struct {
        logic [3:0] btn;
        logic       push;
        logic [3:0] lvl;
        logic       valid;
        logic [2:0] code;
        logic       ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ready = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic       valid;
    logic [2:0] code;
    logic [3:0] lvl;
    logic       ovr;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ovr_cnt = 0;
    sb_t  exp_q[$];
    vec_t tv[32];

    always #5 clk = ~clk;

    pmod_input_unit #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_btn(btn),
        .i_cmd_ready(ready),
        .o_cmd_valid(valid),
        .o_cmd_code(code),
        .o_btn_level(lvl),
        .o_overrun(ovr)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] c, input int at);
        sb_t e;
        e.code = c;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic to_neg();
        sb_t e;
        @(negedge clk);
        if (ovr) ovr_cnt++;
        if (rst_n && valid && ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL xfer_extra: code %0d at cycle %0d, none expected",
                         code, cyc);
            end else begin
                e = exp_q.pop_front();
                if (code !== e.code || (e.cyc >= 0 && e.cyc != cyc)) begin
                    n_err++;
                    $display("FAIL xfer: code %0d at cycle %0d, expected code %0d at cycle %0d",
                             code, cyc, e.code, e.cyc);
                end
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            to_neg();
            to_pos();
        end
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 32; i++) begin
            int j;
            j = i - 16;
            if (i < 16) begin
                tv[i].btn   = (i < 8) ? 4'b0010 : 4'b0000;
                tv[i].lvl   = (i >= 6 && i < 14) ? 4'b0010 : 4'b0000;
                tv[i].valid = (i == 6);
            end else begin
                tv[i].btn   = ((j < 3) || (j >= 5 && j < 8)) ? 4'b0001 : 4'b0000;
                tv[i].lvl   = 4'b0000;
                tv[i].valid = 1'b0;
            end
            tv[i].push = (i == 0);
            tv[i].code = 3'd1;
            tv[i].ovr  = 1'b0;
        end

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_code", 32'(code), 0);
        check("rst_lvl", 32'(lvl), 0);
        check("rst_ovr", 32'(ovr), 0);
        rst_n = 1'b1;

        // clean press on button 1, then bounce rejection on button 0
        for (int i = 0; i < 32; i++) begin
            btn   = tv[i].btn;
            ready = 1'b1;
            if (tv[i].push) push(tv[i].code, cyc + 6);
            to_neg();
            n_vec++;
            if (lvl !== tv[i].lvl || valid !== tv[i].valid || ovr !== tv[i].ovr ||
                (tv[i].valid && code !== tv[i].code)) begin
                n_err++;
                $display("FAIL vec[%0d]: lvl=%b valid=%b code=%0d ovr=%b, expected lvl=%b valid=%b code=%0d ovr=%b",
                         i, lvl, valid, code, ovr, tv[i].lvl, tv[i].valid, tv[i].code, tv[i].ovr);
            end
            to_pos();
        end

        c0 = cyc;
        push(3'd0, c0 + 6);
        btn = 4'b0001;
        tick(10);
        btn = 4'b0000;
        tick(12);
        check("sb_drain_t2", exp_q.size(), 0);

        // long press, release, re-press
        c0 = cyc;
        push(3'd2, c0 + 6);
        push(3'd6, c0 + 16);
        btn = 4'b0100;
        tick(30);
        btn = 4'b0000;
        tick(10);
        check("lvl_after_release", 32'(lvl), 0);
        c0 = cyc;
        push(3'd2, c0 + 6);
        push(3'd6, c0 + 16);
        btn = 4'b0100;
        tick(20);
        btn = 4'b0000;
        tick(10);
        check("sb_drain_t3", exp_q.size(), 0);

        // back-pressure and priority
        ready = 1'b0;
        push(3'd0, -1);
        push(3'd3, -1);
        btn = 4'b1001;
        tick(8);
        check("bp_valid", 32'(valid), 1);
        check("bp_code", 32'(code), 0);
        btn = 4'b0000;
        tick(1);
        check("bp_code_hold1", 32'(code), 0);
        tick(1);
        check("bp_code_hold2", 32'(code), 0);
        ready = 1'b1;
        tick(6);
        check("bp_valid_drop", 32'(valid), 0);
        check("sb_drain_t4", exp_q.size(), 0);

        // overrun
        ready = 1'b0;
        c0 = ovr_cnt;
        push(3'd1, -1);
        btn = 4'b0010;
        tick(6);
        btn = 4'b0000;
        tick(6);
        btn = 4'b0010;
        tick(6);
        btn = 4'b0000;
        tick(8);
        check("ovr_pulses", 32'(ovr_cnt - c0), 1);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_code", 32'(code), 1);
        ready = 1'b1;
        tick(4);
        check("ovr_valid_drop", 32'(valid), 0);
        check("sb_drain_t5", exp_q.size(), 0);

        // async reset mid-operation
        c0 = cyc;
        ready = 1'b1;
        push(3'd0, c0 + 6);
        btn = 4'b0001;
        tick(7);
        ready = 1'b0;
        tick(11);
        check("pre_rst_valid", 32'(valid), 1);
        check("pre_rst_code", 32'(code), 4);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 0);
        check("arst_code", 32'(code), 0);
        check("arst_lvl", 32'(lvl), 0);
        check("arst_ovr", 32'(ovr), 0);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        push(3'd0, cyc + 6);
        push(3'd4, cyc + 16);
        tick(20);
        btn = 4'b0000;
        tick(10);
        check("sb_drain_t6", exp_q.size(), 0);
        check("ovr_total", 32'(ovr_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
